// File: rtl/uart_tx_fifo_gpio_if.sv
// Register bus for uart_tx_fifo_gpio: address/data/strobes in, registered read data out.
interface uart_tx_fifo_gpio_if;
  logic [31:0] addr;
  logic [31:0] data_in;
  logic        rd_strobe;
  logic [3:0]  wr_strobe;
  logic [31:0] data_out;

  modport master (output addr, data_in, rd_strobe, wr_strobe, input data_out);
  modport slave  (input addr, data_in, rd_strobe, wr_strobe, output data_out);
endinterface

// File: rtl/uart_tx_fifo_gpio.sv
// Memory-mapped UART transmitter: byte FIFO feeding an 8-bit serializer with
// optional parity and one or two stop bits.
module uart_tx_fifo_gpio #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_fifo_gpio_if.slave   bus,
  output logic                 tx_pin,
  output logic                 irq
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_C = FIFO_DEPTH[AW:0];

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_tx_en, r_parity_en, r_parity_odd, r_two_stop, r_irq_en;
  logic [15:0]   r_div;
  logic          r_ovf;
  logic [31:0]   r_data_out;

  state_t        r_state, w_state_nxt;
  logic [15:0]   r_baud_cnt, r_f_div;
  logic [2:0]    r_bit_cnt;
  logic          r_stop_cnt, r_f_par_en, r_f_two_stop, r_par_bit;
  logic [7:0]    r_shift;

  logic [3:0]    w_sel;
  logic          w_wr, w_wr_data, w_wr_ctrl, w_wr_div, w_rd_status, w_flush;
  logic          w_push, w_pop, w_full, w_empty, w_ovf_set, w_busy, w_bit_done, w_tx;
  logic [7:0]    w_head, w_level;
  logic [15:0]   w_period;
  logic [31:0]   w_status;
  logic          w_unused;

  assign w_sel       = bus.addr[31:28];
  assign w_wr        = !rst && (bus.wr_strobe != 4'h0);
  assign w_wr_data   = w_wr && (w_sel == 4'h2);
  assign w_wr_ctrl   = w_wr && (w_sel == 4'h3);
  assign w_wr_div    = w_wr && (w_sel == 4'h5);
  assign w_rd_status = !rst && bus.rd_strobe && (w_sel == 4'h4);
  assign w_flush     = w_wr_ctrl && bus.data_in[4];

  // Full/empty come from the registered count, so a push into a full FIFO is
  // dropped even when the serializer pops in the same cycle.
  assign w_full    = (r_count == DEPTH_C);
  assign w_empty   = (r_count == '0);
  assign w_push    = w_wr_data && !w_full && !w_flush;
  assign w_ovf_set = w_wr_data && w_full && !w_flush;
  assign w_head    = r_mem[r_rd_ptr];
  assign w_level   = {{(7 - AW){1'b0}}, r_count};
  assign w_busy    = (r_state != S_IDLE);
  assign w_status  = {16'h0, w_level, 4'h0, r_ovf, w_busy, w_full, w_empty};
  assign irq       = r_irq_en && w_empty && !w_busy;
  assign tx_pin    = w_tx;
  assign bus.data_out = r_data_out;
  assign w_unused  = ^{bus.addr[27:0], bus.data_in[31:16]};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= bus.data_in[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_rd_ptr <= r_wr_ptr;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx_en      <= 1'b0;
      r_parity_en  <= 1'b0;
      r_parity_odd <= 1'b0;
      r_two_stop   <= 1'b0;
      r_irq_en     <= 1'b0;
      r_div        <= DIV_RESET;
      r_ovf        <= 1'b0;
      r_data_out   <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_tx_en      <= bus.data_in[0];
        r_parity_en  <= bus.data_in[1];
        r_parity_odd <= bus.data_in[2];
        r_two_stop   <= bus.data_in[3];
        r_irq_en     <= bus.data_in[5];
      end
      if (w_wr_div) r_div <= bus.data_in[15:0];
      if (w_ovf_set)        r_ovf <= 1'b1;
      else if (w_rd_status) r_ovf <= 1'b0;
      if (bus.rd_strobe) begin
        case (w_sel)
          4'h2:    r_data_out <= '0;
          4'h3:    r_data_out <= {26'h0, r_irq_en, 1'b0, r_two_stop, r_parity_odd, r_parity_en, r_tx_en};
          4'h4:    r_data_out <= w_status;
          4'h5:    r_data_out <= {16'h0, r_div};
          default: r_data_out <= r_data_out;
        endcase
      end
    end
  end

  assign w_period   = (r_f_div == '0) ? 16'd1 : r_f_div;
  assign w_bit_done = (r_baud_cnt == (w_period - 16'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_baud_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_stop_cnt   <= 1'b0;
      r_shift      <= '0;
      r_par_bit    <= 1'b0;
      r_f_div      <= '0;
      r_f_par_en   <= 1'b0;
      r_f_two_stop <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_pop) begin
        // Frame settings are captured here so later CTRL/DIV writes wait for the next frame.
        r_shift      <= w_head;
        r_par_bit    <= (^w_head) ^ r_parity_odd;
        r_f_div      <= r_div;
        r_f_par_en   <= r_parity_en;
        r_f_two_stop <= r_two_stop;
        r_baud_cnt   <= '0;
        r_bit_cnt    <= '0;
        r_stop_cnt   <= 1'b0;
      end else if (r_state != S_IDLE) begin
        if (w_bit_done) begin
          r_baud_cnt <= '0;
          if (r_state == S_DATA) begin
            r_shift   <= r_shift >> 1;
            r_bit_cnt <= r_bit_cnt + 1'b1;
          end
          if (r_state == S_STOP) r_stop_cnt <= 1'b1;
        end else begin
          r_baud_cnt <= r_baud_cnt + 1'b1;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_tx        = 1'b1;
    case (r_state)
      S_IDLE: begin
        if (r_tx_en && !w_empty) begin
          w_pop       = 1'b1;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        w_tx = 1'b0;
        if (w_bit_done) w_state_nxt = S_DATA;
      end
      S_DATA: begin
        w_tx = r_shift[0];
        if (w_bit_done && (r_bit_cnt == 3'd7))
          w_state_nxt = r_f_par_en ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        w_tx = r_par_bit;
        if (w_bit_done) w_state_nxt = S_STOP;
      end
      S_STOP: begin
        if (w_bit_done && (r_stop_cnt || !r_f_two_stop)) begin
          if (r_tx_en && !w_empty) begin
            w_pop       = 1'b1;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_tx_fifo_gpio.sv
// Directed bench for uart_tx_fifo_gpio: register access, frame waveforms,
// FIFO overflow/flush, back-to-back frames, interrupt and reset abort.
module tb_uart_tx_fifo_gpio;
  localparam logic [3:0] A_DATA = 4'h2, A_CTRL = 4'h3, A_STAT = 4'h4, A_DIV = 4'h5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic tx_pin, irq;
  int unsigned n_pass = 0;
  int unsigned n_total = 0;

  uart_tx_fifo_gpio_if bus();

  uart_tx_fifo_gpio #(.FIFO_DEPTH(8), .DIV_RESET(16'd868)) dut (
    .clk(clk), .rst(rst), .bus(bus), .tx_pin(tx_pin), .irq(irq)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic bus_write(input logic [3:0] sel, input logic [31:0] d, input logic [3:0] strb);
    @(negedge clk);
    bus.addr = {sel, 28'h0};
    bus.data_in = d;
    bus.wr_strobe = strb;
    @(negedge clk);
    bus.wr_strobe = 4'h0;
  endtask

  task automatic read_check(input string tag, input logic [3:0] sel, input logic [31:0] exp);
    @(negedge clk);
    bus.addr = {sel, 28'h0};
    bus.rd_strobe = 1'b1;
    @(negedge clk);
    bus.rd_strobe = 1'b0;
    check(tag, bus.data_out, exp);
  endtask

  // Samples tx_pin once per cycle for the whole frame; irq must stay low while busy.
  task automatic check_frame(input string tag, input logic [7:0] b, input bit par_en,
                             input logic par_bit, input int unsigned stops, input int unsigned period);
    logic [11:0] bits;
    int unsigned nb;
    bits = '1;
    bits[0] = 1'b0;
    bits[8:1] = b;
    nb = 9;
    if (par_en) begin
      bits[nb] = par_bit;
      nb++;
    end
    nb += stops;
    for (int unsigned i = 0; i < nb; i++) begin
      for (int unsigned c = 0; c < period; c++) begin
        @(negedge clk);
        check($sformatf("%s_bit%0d_c%0d", tag, i, c), {31'h0, tx_pin}, {31'h0, bits[i]});
        check($sformatf("%s_irq%0d", tag, i), {31'h0, irq}, 32'h0);
      end
    end
  endtask

  initial begin
    bus.addr = '0;
    bus.data_in = '0;
    bus.rd_strobe = 1'b0;
    bus.wr_strobe = 4'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tx", {31'h0, tx_pin}, 32'h1);
    check("rst_irq", {31'h0, irq}, 32'h0);
    check("rst_dout", bus.data_out, 32'h0);
    rst = 1'b0;

    read_check("rst_status", A_STAT, 32'h0000_0001);
    read_check("rst_div", A_DIV, 32'h0000_0364);
    read_check("rst_ctrl", A_CTRL, 32'h0);
    bus_write(A_DIV, 32'h1234_0004, 4'h4);
    read_check("div_rb", A_DIV, 32'h0000_0004);
    read_check("data_rd", A_DATA, 32'h0);
    read_check("div_rb2", A_DIV, 32'h0000_0004);
    read_check("unmapped_hold", 4'h7, 32'h0000_0004);

    // 0x55, no parity, DIV=4; busy must cover exactly 40 cycles
    bus_write(A_CTRL, 32'h1, 4'hF);
    bus_write(A_DATA, 32'h55, 4'h8);
    fork
      check_frame("f55", 8'h55, 1'b0, 1'b0, 1, 4);
      begin
        repeat (39) @(negedge clk);
        read_check("busy_last_cycle", A_STAT, 32'h0000_0005);
      end
    join
    read_check("idle_after_f55", A_STAT, 32'h0000_0001);

    bus_write(A_DIV, 32'h2, 4'hF);
    bus_write(A_CTRL, 32'h7, 4'hF);
    bus_write(A_DATA, 32'h03, 4'hF);
    check_frame("odd03", 8'h03, 1'b1, 1'b1, 1, 2);
    bus_write(A_CTRL, 32'h3, 4'hF);
    bus_write(A_DATA, 32'h03, 4'hF);
    check_frame("even03", 8'h03, 1'b1, 1'b0, 1, 2);

    // two stop bits: second frame start time exposes the stop length
    bus_write(A_CTRL, 32'h8, 4'hF);
    bus_write(A_DATA, 32'hA5, 4'hF);
    bus_write(A_DATA, 32'h3C, 4'hF);
    bus_write(A_CTRL, 32'h9, 4'hF);
    check_frame("stop2_a5", 8'hA5, 1'b0, 1'b0, 2, 2);
    check_frame("stop2_3c", 8'h3C, 1'b0, 1'b0, 2, 2);

    bus_write(A_CTRL, 32'h0, 4'hF);
    for (int i = 0; i < 9; i++) bus_write(A_DATA, 32'h40 + i, 4'h1);
    read_check("ovf_status1", A_STAT, 32'h0000_080A);
    read_check("ovf_status2", A_STAT, 32'h0000_0802);
    bus_write(A_CTRL, 32'h2E, 4'hF);
    read_check("ctrl_rb", A_CTRL, 32'h0000_002E);
    check("irq_nonempty", {31'h0, irq}, 32'h0);
    bus_write(A_CTRL, 32'h30, 4'hF);
    read_check("flush_status", A_STAT, 32'h0000_0001);
    read_check("flush_ctrl", A_CTRL, 32'h0000_0020);
    check("irq_after_flush", {31'h0, irq}, 32'h1);

    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_DIV, 32'h1, 4'hF);
    bus_write(A_CTRL, 32'h20, 4'hF);
    check("irq_idle_empty", {31'h0, irq}, 32'h1);
    bus_write(A_DATA, 32'hC3, 4'hF);
    check("irq_queued", {31'h0, irq}, 32'h0);
    bus_write(A_DATA, 32'h81, 4'hF);
    bus_write(A_DATA, 32'h7E, 4'hF);
    bus_write(A_CTRL, 32'h21, 4'hF);
    check_frame("b2b_c3", 8'hC3, 1'b0, 1'b0, 1, 1);
    check_frame("b2b_81", 8'h81, 1'b0, 1'b0, 1, 1);
    check_frame("b2b_7e", 8'h7E, 1'b0, 1'b0, 1, 1);
    @(negedge clk);
    check("irq_after_last", {31'h0, irq}, 32'h1);
    read_check("b2b_status", A_STAT, 32'h0000_0001);

    // flush and tx_en clear plus DIV change mid-frame: frame 1 unaffected, nothing after
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_DIV, 32'h2, 4'hF);
    bus_write(A_DATA, 32'h11, 4'hF);
    bus_write(A_DATA, 32'h22, 4'hF);
    bus_write(A_DATA, 32'h33, 4'hF);
    bus_write(A_DATA, 32'h44, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    fork
      check_frame("flush_f1", 8'h11, 1'b0, 1'b0, 1, 2);
      begin
        repeat (5) @(negedge clk);
        bus_write(A_DIV, 32'h7, 4'h2);
        bus_write(A_CTRL, 32'h10, 4'h1);
      end
    join
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("flush_idle%0d", i), {31'h0, tx_pin}, 32'h1);
    end
    read_check("flush2_status", A_STAT, 32'h0000_0001);
    read_check("flush2_ctrl", A_CTRL, 32'h0);
    read_check("flush2_div", A_DIV, 32'h0000_0007);

    // reset during a data bit, with a bus write that must be ignored
    bus_write(A_DIV, 32'h4, 4'hF);
    bus_write(A_CTRL, 32'h0, 4'hF);
    bus_write(A_DATA, 32'h00, 4'hF);
    bus_write(A_DATA, 32'h00, 4'hF);
    bus_write(A_CTRL, 32'h1, 4'hF);
    @(negedge clk);
    check("abort_start", {31'h0, tx_pin}, 32'h0);
    repeat (4) @(negedge clk);
    check("abort_data0", {31'h0, tx_pin}, 32'h0);
    read_check("abort_div_pre", A_DIV, 32'h0000_0004);
    @(negedge clk);
    rst = 1'b1;
    bus.addr = {A_DATA, 28'h0};
    bus.data_in = 32'hFF;
    bus.wr_strobe = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    bus.wr_strobe = 4'h0;
    check("abort_tx", {31'h0, tx_pin}, 32'h1);
    check("abort_dout", bus.data_out, 32'h0);
    check("abort_irq", {31'h0, irq}, 32'h0);
    read_check("abort_status", A_STAT, 32'h0000_0001);
    read_check("abort_div", A_DIV, 32'h0000_0364);
    read_check("abort_ctrl", A_CTRL, 32'h0);
    check("abort_tx_hold", {31'h0, tx_pin}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/uart_tx_fifo_gpio.md
UART_TX_FIFO_GPIO -- requirements
Module: uart_tx_fifo_gpio

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX FIFO entries; power of 2, range 2..64.
REQ-002 SHALL have parameter DIV_RESET, default 16'd868, baud divisor reset value in clk cycles per bit.
REQ-003 SHALL have port clk  input  1  system clock; all logic on rising edge; one clock only.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port addr  input  32  bus address; register select on addr[31:28].
REQ-006 SHALL have port data_in  input  32  write data.
REQ-007 SHALL have port rd_strobe  input  1  read request, one cycle.
REQ-008 SHALL have port wr_strobe  input  4  byte write enables; any bit set = full 32-bit write.
REQ-009 SHALL have port data_out  output  32  registered read data.
REQ-010 SHALL have port tx_pin  output  1  serial line; idle high.
REQ-011 SHALL have port irq  output  1  level interrupt: CTRL.irq_en & FIFO empty & serializer idle.

Function
REQ-012 SHALL decode addr[31:28]: 0x2 DATA (W), 0x3 CTRL (R/W), 0x4 STATUS (R), 0x5 DIV (R/W); other values ignored, data_out unchanged.
REQ-013 SHALL give 1-cycle read latency: data_out loads on the clk edge sampling rd_strobe and holds until the next decoded read.
REQ-014 SHALL read CTRL as {26'h0, irq_en, 1'b0, two_stop, parity_odd, parity_en, tx_en}; DIV as {16'h0, div[15:0]}; DATA reads 32'h0.
REQ-015 SHALL read STATUS as {16'h0, level[7:0], 4'h0, overflow, busy, full, empty}.
REQ-016 SHALL, on a DATA write with FIFO not full, push data_in[7:0]; when full, drop the byte and set sticky overflow.
REQ-017 SHALL clear overflow on the STATUS read edge; the read returns the pre-clear value; a same-cycle overflow event wins (overflow stays 1).
REQ-018 SHALL treat CTRL bit4 as write-1 self-clearing flush: empties FIFO (level=0) that cycle; an in-flight frame completes; a same-cycle DATA push is dropped without setting overflow.
REQ-019 SHALL evaluate FIFO full/empty at cycle start: simultaneous push and pop when full drops the push (overflow set); when empty no pop occurs and the push succeeds.
REQ-020 SHALL run serializer FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 SHALL leave IDLE when tx_en=1 and FIFO not empty: pop head into shift register, latch div, parity_en, parity_odd, two_stop, enter START the same edge.
REQ-022 SHALL hold each bit for max(div,1) clk cycles; div=0 behaves as 1.
REQ-023 SHALL drive tx_pin 0 in START, data LSB first over 8 bits in DATA, parity in PARITY (even: XOR of data; odd: inverted), 1 in STOP for 1 or 2 bit periods.
REQ-024 SHALL skip PARITY when latched parity_en=0.
REQ-025 SHALL, at end of STOP, start the next frame directly (no idle gap) if tx_en=1 and FIFO not empty, else go to IDLE.
REQ-026 SHALL make CTRL/DIV writes mid-frame affect only subsequent frames; clearing tx_en mid-frame completes the current frame.
REQ-027 SHALL assert busy in every state except IDLE.
REQ-028 SHALL keep level = number of FIFO entries, 0..FIFO_DEPTH, zero-extended to 8 bits.

Reset
REQ-029 SHALL on rst: FSM IDLE, tx_pin=1, FIFO empty, overflow=0, CTRL=0, div=DIV_RESET, data_out=32'h0, irq=0.
REQ-030 SHALL abort any frame in progress on rst; tx_pin high on the cycle after the reset edge.
REQ-031 SHALL ignore bus reads and writes in a cycle where rst=1.

Verification
REQ-032 SHALL cover: DIV=4, CTRL=0x1, DATA=0x55 -> tx_pin 0, then 1,0,1,0,1,0,1,0, then 1, each held 4 cycles; busy 40 cycles after the start.
REQ-033 SHALL cover: CTRL=0x7 (odd parity), DIV=2, DATA=0x03 -> parity bit 1; CTRL=0x3 -> parity bit 0; CTRL=0x9 -> stop 4 cycles.
REQ-034 SHALL cover: tx_en=0, 9 DATA writes, FIFO_DEPTH=8 -> STATUS=0x0000_080A; second STATUS read -> 0x0000_0802.
REQ-035 SHALL cover: 3 bytes queued, tx_en=1, DIV=1 -> three back-to-back 10-cycle frames, no idle gap; with CTRL=0x21, irq rises after the last stop bit.
REQ-036 SHALL cover: rst asserted mid-DATA-bit -> tx_pin=1 next cycle, STATUS=0x0000_0001, DIV reads 868.
REQ-037 SHALL cover: flush during frame 1 of 4 queued -> frame 1 completes, level=0, no further frames.
